mul_div_unit: RTL and testbench

Iterative multiply/divide unit. Takes two operands and an opcode, runs a shift-add multiply or a restoring divide over BIT_WIDTH cycles, and presents a double-width result on hi/lo with a one-cycle done pulse. It sits directly upstream of the HI/LO result registers: done drives their en_write, and hi/lo drive their data_in. The execute-stage stall logic uses busy to hold the pipeline.

---
 rtl/mul_div_pkg.sv | 31 +++
 rtl/mul_div_if.sv | 33 +++
 rtl/Register.sv | 32 +++
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 tb/tb_mul_div_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_div_pkg                                                     |
// | Purpose  : Shared opcode and state encodings for the multiply/divide unit, |
// |            plus small opcode decode helpers.                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mul_div_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // The upper opcode bit selects divide; the lower bit selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_div_if                                                      |
// | Purpose  : Request/result bundle of the multiply/divide unit.              |
// | Ports    : start, op, a, b          (requester -> unit)                    |
// |            busy, done, hi, lo, div_by_zero (unit -> requester)             |
// |            master = requester side, slave = unit side.                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mul_div_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 busy;
  logic                 done;
  logic [BIT_WIDTH-1:0] hi;
  logic [BIT_WIDTH-1:0] lo;
  logic                 div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/Register.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : Register                                                        |
// | Purpose  : Write-enabled holding register with synchronous reset.          |
// | Ports    : clk, reset (sync, active-high), en_write, data_in, data_out     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module Register #(
  parameter int                   BIT_WIDTH   = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 en_write,
  input  wire logic [BIT_WIDTH-1:0] data_in,
  output      logic [BIT_WIDTH-1:0] data_out
);

  logic [BIT_WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= RESET_VALUE;
    end else if (en_write) begin
      r_data <= data_in;
    end
  end

  assign data_out = r_data;

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_div_unit                                                    |
// | Purpose  : Iterative shift-add multiply / restoring divide. One iteration  |
// |            per cycle for BIT_WIDTH cycles, then a sign-correction cycle;   |
// |            hi/lo are registered with a one-cycle done pulse.               |
// | Ports    : clk, reset (sync, active-high)                                  |
// |            bus (mul_div_if.slave): start/op/a/b in, busy/done/hi/lo/       |
// |            div_by_zero out                                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int CNT_WIDTH = 6
) (
  input wire logic  clk,
  input wire logic  reset,
  mul_div_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(BIT_WIDTH - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [1:0]             r_op;
  logic                   r_neg_q;       // product / quotient needs negation
  logic                   r_neg_r;       // remainder needs negation (dividend sign)
  logic                   r_dbz_op;      // divide with zero divisor
  logic [BIT_WIDTH-1:0]   r_opb;         // |multiplicand| or |divisor|
  logic [2*BIT_WIDTH-1:0] r_acc;         // MUL: {partial, multiplier}; DIV: {rem, quot}
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_done;
  logic                   r_div_by_zero;

  logic                   w_accept;
  logic                   w_signed;
  logic [BIT_WIDTH-1:0]   w_a_abs;
  logic [BIT_WIDTH-1:0]   w_b_abs;
  logic [BIT_WIDTH:0]     w_mul_sum;
  logic [2*BIT_WIDTH-1:0] w_mul_next;
  logic [BIT_WIDTH:0]     w_div_shift;
  logic [BIT_WIDTH+1:0]   w_div_trial;
  logic [2*BIT_WIDTH-1:0] w_div_next;
  logic [2*BIT_WIDTH-1:0] w_prod;
  logic [BIT_WIDTH-1:0]   w_quot;
  logic [BIT_WIDTH-1:0]   w_rem;
  logic [BIT_WIDTH-1:0]   w_hi_in;
  logic [BIT_WIDTH-1:0]   w_lo_in;
  logic [BIT_WIDTH-1:0]   w_hi;
  logic [BIT_WIDTH-1:0]   w_lo;
  logic                   w_finish;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_finish = (r_state == S_FINISH);
  assign w_signed = op_is_signed(bus.op);
  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign w_a_abs  = (w_signed && bus.a[BIT_WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_abs  = (w_signed && bus.b[BIT_WIDTH-1]) ? -bus.b : bus.b;

  // ---------------- state machine ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_next = S_RUN;
      S_RUN:    if (r_cnt == c_cnt_last) w_state_next = S_FINISH;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // ---------------- iteration step ----------------
  // Multiply: add multiplicand into the upper half when the current multiplier
  // bit is set, then shift the whole accumulator right (carry shifts in).
  assign w_mul_sum  = {1'b0, r_acc[2*BIT_WIDTH-1:BIT_WIDTH]} + {1'b0, r_opb};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[BIT_WIDTH-1:1]}
                               : {1'b0, r_acc[2*BIT_WIDTH-1:1]};

  // Divide: shift next dividend bit into the remainder, trial-subtract; the
  // extra top bit of the trial result is its sign.
  assign w_div_shift = {r_acc[2*BIT_WIDTH-1:BIT_WIDTH], r_acc[BIT_WIDTH-1]};
  assign w_div_trial = {1'b0, w_div_shift} - {2'b00, r_opb};
  assign w_div_next  = w_div_trial[BIT_WIDTH+1]
                     ? {w_div_shift[BIT_WIDTH-1:0], r_acc[BIT_WIDTH-2:0], 1'b0}
                     : {w_div_trial[BIT_WIDTH-1:0], r_acc[BIT_WIDTH-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op          <= OP_MUL;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dbz_op      <= 1'b0;
      r_opb         <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_op          <= bus.op;
        r_neg_q       <= w_signed && (bus.a[BIT_WIDTH-1] ^ bus.b[BIT_WIDTH-1]);
        r_neg_r       <= w_signed && bus.a[BIT_WIDTH-1];
        r_dbz_op      <= op_is_div(bus.op) && (bus.b == '0);
        r_opb         <= w_b_abs;
        r_acc         <= {{BIT_WIDTH{1'b0}}, w_a_abs};
        r_cnt         <= '0;
        r_div_by_zero <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_acc <= op_is_div(r_op) ? w_div_next : w_mul_next;
        r_cnt <= r_cnt + 1'b1;
      end else if (w_finish) begin
        r_div_by_zero <= r_dbz_op;
      end
    end
  end

  // ---------------- sign correction ----------------
  // With a zero divisor the restoring loop leaves rem = |a| and quot = all ones;
  // the dividend-sign correction restores a exactly, so only lo needs overriding.
  assign w_prod  = r_neg_q ? -r_acc : r_acc;
  assign w_quot  = r_dbz_op ? '1
                 : (r_neg_q ? -r_acc[BIT_WIDTH-1:0] : r_acc[BIT_WIDTH-1:0]);
  assign w_rem   = r_neg_r ? -r_acc[2*BIT_WIDTH-1:BIT_WIDTH]
                           : r_acc[2*BIT_WIDTH-1:BIT_WIDTH];
  assign w_hi_in = op_is_div(r_op) ? w_rem  : w_prod[2*BIT_WIDTH-1:BIT_WIDTH];
  assign w_lo_in = op_is_div(r_op) ? w_quot : w_prod[BIT_WIDTH-1:0];

  Register #(.BIT_WIDTH(BIT_WIDTH), .RESET_VALUE('0)) u_hi_reg (
    .clk      (clk),
    .reset    (reset),
    .en_write (w_finish),
    .data_in  (w_hi_in),
    .data_out (w_hi)
  );

  Register #(.BIT_WIDTH(BIT_WIDTH), .RESET_VALUE('0)) u_lo_reg (
    .clk      (clk),
    .reset    (reset),
    .en_write (w_finish),
    .data_in  (w_lo_in),
    .data_out (w_lo)
  );

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.hi          = w_hi;
  assign bus.lo          = w_lo;
  assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mul_div_unit                                                 |
// | Purpose  : Self-checking bench for mul_div_unit: directed corner cases,    |
// |            handshake/reset scenarios and randomized operations compared    |
// |            against a plain-arithmetic reference model.                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int BW = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mul_div_if #(.BIT_WIDTH(BW)) bus ();

  mul_div_unit #(.BIT_WIDTH(BW), .CNT_WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: straight 64-bit arithmetic on the operands.
  task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint     sa;
    longint     sb;
    longint     q;
    longint     r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    case (op)
      OP_MUL: begin
        p  = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      OP_MULU: begin
        p  = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          dbz = 1'b1;
          lo  = 32'hFFFF_FFFF;
          hi  = a;
        end else if (op == OP_DIV) begin
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endtask

  // Issue one operation at the current negedge and check its result, latency
  // and the state in the cycle after done. Leaves the caller at a negedge.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] eh;
    logic [31:0] el;
    logic        ed;
    int          cyc;
    ref_op(op, a, b, eh, el, ed);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 2'($urandom_range(0, 3));
    cyc = 1;
    check_eq({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, " latency"}, 64'(cyc), 64'd34);
    check_eq({tag, " hi"}, 64'(bus.hi), 64'(eh));
    check_eq({tag, " lo"}, 64'(bus.lo), 64'(el));
    check_eq({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(ed));
    @(negedge clk);
    check_eq({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    check_eq({tag, " busy_dropped"}, 64'(bus.busy), 64'd0);
    check_eq({tag, " hold"}, {bus.hi, bus.lo}, {eh, el});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          ndone;
    int          done_cyc;
    logic [31:0] lo_seen;
    logic [31:0] hi_seen;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset busy", 64'(bus.busy), 64'd0);
    check_eq("reset done", 64'(bus.done), 64'd0);
    check_eq("reset hilo", {bus.hi, bus.lo}, 64'd0);
    check_eq("reset dbz", 64'(bus.div_by_zero), 64'd0);

    // Directed cases; successive calls also start in the cycle after done.
    do_op(OP_MUL,  32'hFFFF_FFFD, 32'h0000_0007, "mul_neg");
    do_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max");
    do_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
    do_op(OP_DIVU, 32'h0000_0064, 32'h0000_0007, "divu");
    do_op(OP_DIVU, 32'h0000_0064, 32'h0000_0000, "divu_zero");
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0000, "div_zero_neg");
    do_op(OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, "div_negb");
    do_op(OP_MUL,  32'h8000_0000, 32'h8000_0000, "mul_minmin");

    // start pulses while busy (mid-RUN and in FINISH) must be ignored.
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    ndone     = 0;
    done_cyc  = 0;
    lo_seen   = '0;
    hi_seen   = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        done_cyc = c;
        lo_seen  = bus.lo;
        hi_seen  = bus.hi;
      end
      bus.start = (c == 10 || c == 33);
      bus.op    = OP_DIVU;
      bus.a     = $urandom;
      bus.b     = $urandom;
    end
    check_eq("busy_start done_count", 64'(ndone), 64'd1);
    check_eq("busy_start done_cycle", 64'(done_cyc), 64'd34);
    check_eq("busy_start result", {hi_seen, lo_seen}, 64'h0000_0000_0000_001E);

    // Reset mid-operation: leave non-zero results first, then abort a divide.
    do_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "pre_reset");
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h0000_0013;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_reset busy", 64'(bus.busy), 64'd0);
    check_eq("mid_reset hilo", {bus.hi, bus.lo}, 64'd0);
    check_eq("mid_reset dbz", 64'(bus.div_by_zero), 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clk);
    end
    check_eq("mid_reset no_done", 64'(ndone), 64'd0);
    do_op(OP_MUL, 32'd2, 32'd3, "post_reset");

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      do_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
